// File: rtl/fib_request_arbiter_pkg.sv
// fib_request_arbiter_pkg
// Shared FSM state type and default sizing for the Fibonacci request arbiter.
package fib_request_arbiter_pkg;

    localparam int NUM_REQ_DEF     = 4;   // requesters sharing one generator
    localparam int DATA_W_DEF      = 16;  // operand/result width
    localparam int TIMEOUT_CYC_DEF = 64;  // watchdog limit in WAIT cycles

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/fib_request_arbiter_rr_pick.sv
// fib_request_arbiter_rr_pick
// Combinational round-robin picker: starting at rr_ptr_i and wrapping modulo
// NUM_REQ, returns the first asserted request as one-hot plus its index.
module fib_request_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   index_o,
    output logic               any_o
);

    // Walk the ring from rr_ptr_i; the first requester found wins.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        logic             found;
        // NOTE: every output and temporary gets a default before any
        // conditional assignment, so no path leaves a value held (no latch).
        grant_o = '0;
        index_o = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr_i and k are both below NUM_REQ, so one subtraction wraps.
            sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                index_o       = cand;
                grant_o[cand] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/fib_request_arbiter.sv
// fib_request_arbiter
// Shares one Fibonacci generator among NUM_REQ requesters. A round-robin pick
// in IDLE latches one operand, START pulses the generator, WAIT captures the
// result on a rising gen_done, RESP returns it to the granted requester.
// Optional feature: define FIB_ARB_TIMEOUT_EN to add a WAIT watchdog that
// ends the transaction after TIMEOUT_CYC cycles with an all-ones result.
module fib_request_arbiter
    import fib_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_number,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      gen_start,
    output logic [DATA_W-1:0]         gen_number_in,
    input  logic                      gen_done,
    input  logic [DATA_W-1:0]         gen_number_out,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e          state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                gen_start_q;
    logic [DATA_W-1:0]   operand_q;
    logic                busy_q;
    logic                done_prev_q;

`ifdef FIB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                timeout_err_q;
`endif

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [DATA_W-1:0]   pick_operand;
    logic [NUM_REQ-1:0]  idx_onehot;
    logic                done_rise;

    fib_request_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pick_onehot),
        .index_o  (pick_idx),
        .any_o    (pick_any)
    );

    // Select the winning requester's operand slice from the flattened bus.
    always_comb begin
        pick_operand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_operand = req_number[i*DATA_W +: DATA_W];
            end
        end
    end

    assign idx_onehot = NUM_REQ'(1) << idx_q;
    // Only a 0->1 transition counts, so a level left high from a previous
    // transaction cannot complete the current one.
    assign done_rise  = gen_done & ~done_prev_q;

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            gen_start_q <= 1'b0;
            operand_q   <= '0;
            busy_q      <= 1'b0;
            done_prev_q <= 1'b0;
`ifdef FIB_ARB_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values regardless of statement order.
            done_prev_q <= gen_done;
            // Pulse outputs default low and are raised only for their cycle.
            grant_q     <= '0;
            gen_start_q <= 1'b0;
            rsp_valid_q <= '0;
`ifdef FIB_ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q     <= pick_onehot;
                        idx_q       <= pick_idx;
                        operand_q   <= pick_operand;
                        gen_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_START;
                    end
                end
                ST_START: begin
`ifdef FIB_ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_rise) begin
                        rsp_data_q  <= gen_number_out;
                        rsp_valid_q <= idx_onehot;
                        state_q     <= ST_RESP;
                    end
`ifdef FIB_ARB_TIMEOUT_EN
                    else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rsp_data_q    <= '1;
                        rsp_valid_q   <= idx_onehot;
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    rsp_data_q <= '0;
                    operand_q  <= '0;
                    busy_q     <= 1'b0;
                    rr_ptr_q   <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant         = grant_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign gen_start     = gen_start_q;
    assign gen_number_in = operand_q;
    assign busy          = busy_q;
`ifdef FIB_ARB_TIMEOUT_EN
    assign timeout_err   = timeout_err_q;
`else
    assign timeout_err   = 1'b0;
`endif

endmodule
